fetch_ctrl: RTL and testbench

- Fetch-stage sequencer. Owns the fetch PC and drives a single-outstanding instruction-memory request/response handshake.
- Arbitrates PC redirects: exception/ertn from WB has priority over branch/jump from EX. Discards in-flight responses made stale by a redirect.
- Holds one fetched instruction in an output buffer until decode accepts it.
- Sits between the branch/exception buses and the IF/ID pipeline register.

---
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// fetch_ctrl: fetch-stage sequencer.
// Owns the fetch PC and runs a single-outstanding instruction-memory
// request/response handshake. WB exceptions/ertn take priority over EX
// branches/jumps. Responses made stale by a redirect are dropped. One fetched
// instruction is held in an output buffer until decode accepts it.
// Optional feature: define FETCH_PERF_CNT_EN to add fetch/discard counters.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c000000)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [32:0]       jbr_bus_i,
    input  logic [32:0]       excp_bus_i,
    input  logic              id_allowin_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [31:0]       inst_rdata_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_discard_cnt_o,
`endif
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    // Increment applied to the word-index part of the PC (pc[ADDR_W-1:2]).
    localparam logic [ADDR_W-3:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_seq;
    logic              discard;
    logic              discard_nxt;
    logic [31:0]       inst_buf;
    logic [31:0]       inst_nxt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;

    // Redirect arbitration: an exception/ertn from WB overrides a branch from EX.
    always_comb begin
        redirect        = excp_bus_i[32] | jbr_bus_i[32];
        redirect_target = excp_bus_i[32] ? ADDR_W'(excp_bus_i[31:0])
                                         : ADDR_W'(jbr_bus_i[31:0]);
    end

    // Sequential PC steps the word index only, so the low two bits pass through
    // and the all-ones word address wraps to zero.
    assign pc_seq = {pc[ADDR_W-1:2] + PC_STEP, pc[1:0]};

    // Next-state, next-PC, discard-flag and buffer-capture decisions.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        inst_nxt    = inst_buf;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_nxt = redirect_target;
                end
                if (inst_addr_ok_i) begin
                    state_nxt   = S_WAIT;
                    discard_nxt = redirect;
                end
            end
            S_WAIT: begin
                if (inst_data_ok_i) begin
                    if (discard || redirect) begin
                        state_nxt   = S_REQ;
                        discard_nxt = 1'b0;
                        if (redirect) begin
                            pc_nxt = redirect_target;
                        end
                    end else begin
                        state_nxt = S_OUT;
                        inst_nxt  = inst_rdata_i;
                    end
                end else if (redirect) begin
                    discard_nxt = 1'b1;
                    pc_nxt      = redirect_target;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    state_nxt = S_REQ;
                    pc_nxt    = redirect_target;
                end else if (id_allowin_i) begin
                    state_nxt = S_REQ;
                    pc_nxt    = pc_seq;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, discard flag and instruction buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc       <= RESET_PC;
            discard  <= 1'b0;
            inst_buf <= 32'h0;
        end else begin
            pc       <= pc_nxt;
            discard  <= discard_nxt;
            inst_buf <= inst_nxt;
        end
    end

    assign inst_req_o  = (state == S_REQ);
    assign inst_addr_o = pc;
    assign if_valid_o  = (state == S_OUT);
    assign if_pc_o     = pc;
    assign if_inst_o   = inst_buf;

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_fire;
    logic        drop_fire;
    logic [31:0] fetch_cnt;
    logic [31:0] discard_cnt;

    assign fetch_fire = (state == S_OUT) && id_allowin_i && !redirect;
    assign drop_fire  = (state == S_WAIT) && inst_data_ok_i && (discard || redirect);

    // Free-running counters of accepted fetches and dropped responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt   <= 32'h0;
            discard_cnt <= 32'h0;
        end else begin
            if (fetch_fire) begin
                fetch_cnt <= fetch_cnt + 32'h1;
            end
            if (drop_fire) begin
                discard_cnt <= discard_cnt + 32'h1;
            end
        end
    end

    assign perf_fetch_cnt_o   = fetch_cnt;
    assign perf_discard_cnt_o = discard_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
// tb_fetch_ctrl: directed stimulus with a scoreboard for fetch_ctrl.
// Expected accepted request addresses and expected presented instructions are
// queued by the stimulus; monitors pop and compare when the DUT hands off.
module tb_fetch_ctrl;

    localparam logic [32:0] NONE = 33'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } out_t;

    logic        clk;
    logic        rst;
    logic [32:0] jbr_bus;
    logic [32:0] excp_bus;
    logic        id_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    int          checks;
    int          failures;
    logic [31:0] req_q[$];
    out_t        out_q[$];
    logic        prev_valid;
    logic [31:0] exp_addr;
    out_t        exp_out;

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h1c000000)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .jbr_bus_i          (jbr_bus),
        .excp_bus_i         (excp_bus),
        .id_allowin_i       (id_allowin),
        .inst_req_o         (inst_req),
        .inst_addr_o        (inst_addr),
        .inst_addr_ok_i     (inst_addr_ok),
        .inst_data_ok_i     (inst_data_ok),
        .inst_rdata_i       (inst_rdata),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt_o   (perf_fetch_cnt),
        .perf_discard_cnt_o (perf_discard_cnt),
`endif
        .if_valid_o         (if_valid),
        .if_pc_o            (if_pc),
        .if_inst_o          (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents model: each word's data is derived from its address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1ns after the rising edge.
    task automatic applyStimulus(input logic [32:0] jbr, input logic [32:0] excp,
                                 input logic allowin, input logic addr_ok,
                                 input logic data_ok, input logic [31:0] rdata);
        jbr_bus      = jbr;
        excp_bus     = excp;
        id_allowin   = allowin;
        inst_addr_ok = addr_ok;
        inst_data_ok = data_ok;
        inst_rdata   = rdata;
        @(posedge clk);
        #1;
    endtask

    // From S_REQ: accept immediately, respond immediately; ends in S_OUT.
    task automatic runTxn(input logic [31:0] addr);
        req_q.push_back(addr);
        out_q.push_back('{pc: addr, inst: memData(addr)});
        applyStimulus(NONE, NONE, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(NONE, NONE, 1'b1, 1'b0, 1'b1, memData(addr));
    endtask

    task automatic acceptOut();
        applyStimulus(NONE, NONE, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Request monitor: every accepted request must match the next expected address.
    always @(negedge clk) begin
        if (!rst && inst_req && inst_addr_ok) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_req actual=%h expected=none", inst_addr);
            end else begin
                exp_addr = req_q.pop_front();
                checkOutput("req_addr", inst_addr, exp_addr);
            end
        end
    end

    // Output monitor: each new presentation to decode must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && if_valid && !prev_valid) begin
            if (out_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_out actual=%h/%h expected=none", if_pc, if_inst);
            end else begin
                exp_out = out_q.pop_front();
                checkOutput("out_pc", if_pc, exp_out.pc);
                checkOutput("out_inst", if_inst, exp_out.inst);
            end
        end
        prev_valid = if_valid;
    end

    initial begin
        checks       = 0;
        failures     = 0;
        prev_valid   = 1'b0;
        rst          = 1'b1;
        jbr_bus      = NONE;
        excp_bus     = NONE;
        id_allowin   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_req", {31'h0, inst_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rst_addr", inst_addr, 32'h1c000000);
        checkOutput("rst_pc", if_pc, 32'h1c000000);
        checkOutput("rst_inst", if_inst, 32'h0);
        rst = 1'b0;

        // Idle cycle ignores a redirect
        applyStimulus({1'b1, 32'h1c000900}, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("idle_redir_addr", inst_addr, 32'h1c000000);
        checkOutput("req_after_idle", {31'h0, inst_req}, 32'h1);

        // Back-to-back fetches
        runTxn(32'h1c000000);
        acceptOut();
        runTxn(32'h1c000004);
        acceptOut();
        runTxn(32'h1c000008);

        // Decode stall holds the buffer
        for (int i = 0; i < 5; i++) begin
            applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_valid", {31'h0, if_valid}, 32'h1);
            checkOutput("stall_pc", if_pc, 32'h1c000008);
            checkOutput("stall_inst", if_inst, memData(32'h1c000008));
            checkOutput("stall_req", {31'h0, inst_req}, 32'h0);
            checkOutput("stall_addr", inst_addr, 32'h1c000008);
        end
        acceptOut();
        checkOutput("seq_addr", inst_addr, 32'h1c00000c);

        // Branch while waiting: owed response dropped three cycles later
        req_q.push_back(32'h1c00000c);
        applyStimulus(NONE, NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus({1'b1, 32'h1c000100}, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b1, 32'hbad0bad0);
        checkOutput("drop_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("drop_req", {31'h0, inst_req}, 32'h1);
        checkOutput("drop_addr", inst_addr, 32'h1c000100);
        runTxn(32'h1c000100);

        // Exception and branch together in S_OUT with decode ready
        applyStimulus({1'b1, 32'h1c000100}, {1'b1, 32'h1c000800}, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("excp_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("excp_req", {31'h0, inst_req}, 32'h1);
        checkOutput("excp_addr", inst_addr, 32'h1c000800);
        runTxn(32'h1c000800);
        acceptOut();
        checkOutput("excp_seq_addr", inst_addr, 32'h1c000804);

        // Redirect in S_REQ without addr_ok changes the address in place
        applyStimulus({1'b1, 32'hfffffffc}, NONE, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("req_redir_req", {31'h0, inst_req}, 32'h1);
        checkOutput("req_redir_addr", inst_addr, 32'hfffffffc);

        // PC wrap
        runTxn(32'hfffffffc);
        acceptOut();
        checkOutput("wrap_addr", inst_addr, 32'h00000000);

        // Redirect in the same cycle as data_ok
        req_q.push_back(32'h00000000);
        applyStimulus(NONE, NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus({1'b1, 32'h1c000200}, NONE, 1'b0, 1'b0, 1'b1, 32'hbad1bad1);
        checkOutput("same_cyc_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("same_cyc_addr", inst_addr, 32'h1c000200);

        // Redirect in the same cycle as addr_ok
        req_q.push_back(32'h1c000200);
        applyStimulus({1'b1, 32'h1c000300}, NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("acc_redir_req", {31'h0, inst_req}, 32'h0);
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b1, 32'hbad2bad2);
        checkOutput("acc_redir_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("acc_redir_addr", inst_addr, 32'h1c000300);

`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch", perf_fetch_cnt, 32'd5);
        checkOutput("perf_discard", perf_discard_cnt, 32'd3);
`endif

        // Asynchronous reset mid-S_WAIT
        req_q.push_back(32'h1c000300);
        applyStimulus(NONE, NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        inst_addr_ok = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_req", {31'h0, inst_req}, 32'h0);
        checkOutput("arst_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("arst_addr", inst_addr, 32'h1c000000);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("arst_perf_fetch", perf_fetch_cnt, 32'd0);
        checkOutput("arst_perf_discard", perf_discard_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // data_ok in S_IDLE is ignored
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b1, 32'hbad3bad3);
        checkOutput("idle_dok_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("idle_dok_req", {31'h0, inst_req}, 32'h1);
        checkOutput("idle_dok_addr", inst_addr, 32'h1c000000);
        runTxn(32'h1c000000);
        acceptOut();
        checkOutput("post_rst_seq_addr", inst_addr, 32'h1c000004);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("post_rst_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
        applyStimulus(NONE, NONE, 1'b0, 1'b0, 1'b0, 32'h0);

        checkOutput("req_q_empty", 32'(req_q.size()), 32'h0);
        checkOutput("out_q_empty", 32'(out_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
